field_access_engine: RTL

//  Parametrised, pipelined successor to the hITEM field read/write unit.
//  - Field layouts (offset/width/shift/byte-order) live in a runtime-programmable descriptor table, not hard-coded cases.
//  - Requests are queued and processed back-to-back with valid/ready handshakes.
//  - Supports READ, WRITE and INC (atomic read-add-write on count/total fields).
//  - Sits between the SAM sequencer and hPAGE/hBOOK/hINDX word buffers.

---
 rtl/field_access_engine.sv | 136 +++++++++++++
 1 files changed

// File: rtl/field_access_engine.sv
// field_access_engine: descriptor-driven READ/WRITE/INC of bit fields inside a struct image, FIFO + 3-stage pipe.
// Optional SAD_FLD_SATURATE_EN: INC overflow clamps the field to all-ones instead of rejecting.
module field_access_engine #(
  parameter int TGT_BITS = 64,
  parameter int WORDS = 2,
  parameter int NUM_FIELDS = 16,
  parameter int DEPTH = 4,
  localparam int SW = WORDS * TGT_BITS,
  localparam int IDXW = $clog2(NUM_FIELDS)
) (
  input  logic                clk,
  input  logic                rsta,
  input  logic                cfgWe,
  input  logic [IDXW-1:0]     cfgIdx,
  input  logic [21:0]         cfgDesc,
  input  logic                reqValid,
  output logic                reqReady,
  input  logic [1:0]          reqOp,
  input  logic [IDXW-1:0]     reqFld,
  input  logic [SW-1:0]       reqStruct,
  input  logic [TGT_BITS-1:0] reqField,
  output logic                rspValid,
  input  logic                rspReady,
  output logic [SW-1:0]       rspStruct,
  output logic [TGT_BITS-1:0] rspField,
  output logic                rspErr
);
`ifdef SAD_FLD_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int PW = $clog2(DEPTH);
  typedef struct packed {
    logic       bs;
    logic [4:0] sh;
    logic [6:0] w;
    logic [8:0] off;
  } desc_t;
  typedef struct packed {
    logic [1:0]          op;
    logic [SW-1:0]       st;
    logic [TGT_BITS-1:0] fv;
  } req_t;
  function automatic logic [TGT_BITS-1:0] fmask(input logic [6:0] w);
    return {TGT_BITS{1'b1}} >> (TGT_BITS - int'(w));
  endfunction
  // reverse all bytes of the word, then realign so only the low w/8 bytes are swapped
  function automatic logic [TGT_BITS-1:0] brev(input logic [TGT_BITS-1:0] x, input logic [6:0] w);
    logic [TGT_BITS-1:0] r;
    for (int i = 0; i < TGT_BITS / 8; i++) r[8*i +: 8] = x[TGT_BITS-8-8*i +: 8];
    return r >> (TGT_BITS - int'(w));
  endfunction
  req_t ff [DEPTH];
  logic [IDXW-1:0] ff_fld [DEPTH];
  desc_t desc [NUM_FIELDS];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic adv, push, pop;
  logic s1_v, s2_v, s1_err, s2_derr;
  req_t s1_r, s2_r;
  desc_t s1_d, s2_d;
  logic [TGT_BITS-1:0] s1_raw, s1_val, s2_val;
  logic [TGT_BITS:0] sum, wv;
  logic [TGT_BITS-1:0] mk, wb, wf, n_fv;
  logic [SW-1:0] n_st;
  logic wr, lowbad, ovf, sat, n_err;
  assign reqReady = cnt < (PW+1)'(DEPTH);
  assign adv = !rspValid || rspReady;
  assign pop = adv && cnt != '0;
  assign push = reqValid && reqReady;
  always_ff @(posedge clk) begin
    if (push) begin
      ff[wp] <= {reqOp, reqStruct, reqField};
      ff_fld[wp] <= reqFld;
    end
  end
  always_ff @(posedge clk) begin
    if (rsta) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      for (int i = 0; i < NUM_FIELDS; i++) desc[i] <= '0;
    end else begin
      wp <= wp + PW'(push);
      rp <= rp + PW'(pop);
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
      if (cfgWe) desc[cfgIdx] <= cfgDesc;
    end
  end
  always_comb begin
    s1_raw = TGT_BITS'(s1_r.st >> s1_d.off) & fmask(s1_d.w);
    s1_val = (s1_d.bs ? brev(s1_raw, s1_d.w) : s1_raw) << s1_d.sh;
    s1_err = s1_d.w == '0 || int'(s1_d.w) > TGT_BITS || int'(s1_d.off) + int'(s1_d.w) > SW ||
             (s1_d.bs && s1_d.w[2:0] != '0) || s1_r.op == 2'd3;
  end
  // one extra carry bit so INC overflow past the word is still visible to the width check
  always_comb begin
    wr = s2_r.op == 2'd1 || s2_r.op == 2'd2;
    mk = fmask(s2_d.w);
    sum = (s2_r.op == 2'd2 ? {1'b0, s2_val} : '0) + {1'b0, s2_r.fv};
    wv = sum >> s2_d.sh;
    lowbad = (wv << s2_d.sh) != sum;
    ovf = (wv >> s2_d.w) != '0;
    sat = SAT && s2_r.op == 2'd2 && ovf;
    n_err = s2_derr || (wr && (lowbad || (ovf && !sat)));
    wb = sat ? mk : wv[TGT_BITS-1:0];
    wf = s2_d.bs ? brev(wb, s2_d.w) : wb;
    n_st = wr && !n_err ? (s2_r.st & ~(SW'(mk) << s2_d.off)) | (SW'(wf) << s2_d.off) : s2_r.st;
    n_fv = n_err ? '0 : s2_r.op == 2'd0 ? s2_val : s2_r.op == 2'd1 ? s2_r.fv :
           sat ? mk << s2_d.sh : sum[TGT_BITS-1:0];
  end
  always_ff @(posedge clk) begin
    if (rsta) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      rspValid <= 1'b0;
      rspStruct <= '0;
      rspField <= '0;
      rspErr <= 1'b0;
    end else if (adv) begin
      s1_v <= pop;
      s1_r <= ff[rp];
      s1_d <= desc[ff_fld[rp]];
      s2_v <= s1_v;
      s2_r <= s1_r;
      s2_d <= s1_d;
      s2_val <= s1_val;
      s2_derr <= s1_err;
      rspValid <= s2_v;
      rspStruct <= n_st;
      rspField <= n_fv;
      rspErr <= n_err;
    end
  end
endmodule
